// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate, logical and arithmetic shifts in both
// directions over a WIDTH-bit operand. There is one registered stage per
// shift-amount bit. Valid/ready handshakes on both sides, and the whole
// pipeline stalls together on backpressure.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  localparam logic [1:0] OP_ROT = 2'b00;
  localparam logic [1:0] OP_ASH = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Move x by s bit positions in the requested direction and mode. sgn is the
  // original operand MSB and fills vacated bits on arithmetic right shifts.
  // A reserved op passes x through unchanged.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] x,
    input int unsigned      s,
    input logic             dir,
    input logic [1:0]       op,
    input logic             sgn
  );
    logic [WIDTH-1:0] fill;
    fill = '0;
    if (op == OP_RSV) return x;
    if (dir) begin
      if (op == OP_ROT) return (x << s) | (x >> (WIDTH - s));
      return x << s;
    end
    if (op == OP_ROT) return (x >> s) | (x << (WIDTH - s));
    if (op == OP_ASH) fill = {WIDTH{sgn}} << (WIDTH - s);
    return (x >> s) | fill;
  endfunction

  // Per-stage registers. The amt value is kept pre-shifted, so the bit that
  // stage k consumes is always bit 0 of that stage's input.
  logic             valid_q [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic             dir_q   [SHW];
  logic [1:0]       op_q    [SHW];
  logic             sign_q  [SHW];
  logic             err_q   [SHW];
  logic             zero_q  [SHW];

  logic             valid_d [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   amt_d   [SHW];
  logic             dir_d   [SHW];
  logic [1:0]       op_d    [SHW];
  logic             sign_d  [SHW];
  logic             err_d   [SHW];
  logic             zero_d  [SHW];

  // Stage inputs: stage 0 reads the ports, and stage k reads the stage k-1
  // registers.
  logic             st_valid [SHW];
  logic [WIDTH-1:0] st_data  [SHW];
  logic [SHW-1:0]   st_amt   [SHW];
  logic             st_dir   [SHW];
  logic [1:0]       st_op    [SHW];
  logic             st_sign  [SHW];
  logic             st_err   [SHW];

  logic adv;

  // Global advance: the pipeline moves whenever the output slot is empty or
  // is being taken by the consumer.
  always_comb begin
    adv       = !valid_q[SHW-1] || out_ready;
    in_ready  = adv;
    out_valid = valid_q[SHW-1];
    out_data  = data_q[SHW-1];
    out_zero  = zero_q[SHW-1];
    out_err   = err_q[SHW-1];
  end

  // Next-state of every stage: a conditional 2^k move when amt bit k is set.
  always_comb begin
    st_valid[0] = in_valid & adv;
    st_data[0]  = in_data;
    st_amt[0]   = in_amt;
    st_dir[0]   = in_dir;
    st_op[0]    = in_op;
    st_sign[0]  = in_data[WIDTH-1];
    st_err[0]   = (in_op == OP_RSV);
    for (int k = 1; k < SHW; k++) begin
      st_valid[k] = valid_q[k-1];
      st_data[k]  = data_q[k-1];
      st_amt[k]   = amt_q[k-1];
      st_dir[k]   = dir_q[k-1];
      st_op[k]    = op_q[k-1];
      st_sign[k]  = sign_q[k-1];
      st_err[k]   = err_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      valid_d[k] = st_valid[k];
      data_d[k]  = st_amt[k][0]
                   ? shift_by(st_data[k], 1 << k, st_dir[k], st_op[k], st_sign[k])
                   : st_data[k];
      amt_d[k]   = st_amt[k] >> 1;
      dir_d[k]   = st_dir[k];
      op_d[k]    = st_op[k];
      sign_d[k]  = st_sign[k];
      err_d[k]   = st_err[k];
      zero_d[k]  = (data_d[k] == '0);
    end
  end

  // Stage registers: all stages load together on adv. Reset clears every
  // valid bit and the visible output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) valid_q[k] <= 1'b0;
      data_q[SHW-1] <= '0;
      zero_q[SHW-1] <= 1'b0;
      err_q[SHW-1]  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < SHW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        amt_q[k]   <= amt_d[k];
        dir_q[k]   <= dir_d[k];
        op_q[k]    <= op_d[k];
        sign_q[k]  <= sign_d[k];
        err_q[k]   <= err_d[k];
        zero_q[k]  <= zero_d[k];
      end
    end
  end

endmodule
